// File: rtl/obc_shift_accumulator.sv
// Bit-serial offset-binary-coded accumulator: 8 samples are shifted out LSB first
// to drive external ROMs; the summed ROM words are folded into one ACC_W result.
module obc_shift_accumulator #(
  parameter int NBITS = 16,
  parameter int ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NBITS-1:0]        x_in0,
  input  logic [NBITS-1:0]        x_in1,
  input  logic [NBITS-1:0]        x_in2,
  input  logic [NBITS-1:0]        x_in3,
  input  logic [NBITS-1:0]        x_in4,
  input  logic [NBITS-1:0]        x_in5,
  input  logic [NBITS-1:0]        x_in6,
  input  logic [NBITS-1:0]        x_in7,
  input  logic [31:0]             offset_in,
  output logic                    x0,
  output logic                    x1,
  output logic                    x2,
  output logic                    x3,
  output logic                    x4,
  output logic                    x5,
  output logic                    x6,
  output logic                    x7,
  input  logic [31:0]             rom0,
  input  logic [31:0]             rom1,
  input  logic [31:0]             rom2,
  input  logic [31:0]             rom3,
  output logic                    busy,
  output logic                    valid,
  output logic [ACC_W-1:0]        y
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NBITS-1:0]        sr_q [8];
  logic [NBITS-1:0]        sr_d [8];
  logic [NBITS-1:0]        x_in [8];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             off_q, off_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] y_q, y_d;
  logic signed [ACC_W-1:0] sum_s, acc_sum;

  function automatic logic signed [ACC_W-1:0] sext32(input logic [31:0] v);
    return {{(ACC_W-32){v[31]}}, v};
  endfunction

  assign x_in[0] = x_in0;
  assign x_in[1] = x_in1;
  assign x_in[2] = x_in2;
  assign x_in[3] = x_in3;
  assign x_in[4] = x_in4;
  assign x_in[5] = x_in5;
  assign x_in[6] = x_in6;
  assign x_in[7] = x_in7;

  // Four 32-bit words summed at ACC_W >= 34 bits cannot overflow.
  assign sum_s   = sext32(rom0) + sext32(rom1) + sext32(rom2) + sext32(rom3);
  assign acc_sum = acc_q + sum_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    acc_d   = acc_q;
    y_d     = y_q;
    for (int i = 0; i < 8; i++) sr_d[i] = sr_q[i];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) sr_d[i] = x_in[i];
          off_d   = offset_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < 8; i++) sr_d[i] = sr_q[i] >> 1;
        // The sign-bit slice carries negative weight, so it is subtracted.
        if (cnt_q == CNT_W'(NBITS - 1)) begin
          y_d     = acc_q - sum_s + sext32(off_q);
          state_d = DONE;
        end else begin
          acc_d = acc_sum >>> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      for (int i = 0; i < 8; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      for (int i = 0; i < 8; i++) sr_q[i] <= sr_d[i];
    end
  end

  assign x0    = sr_q[0][0];
  assign x1    = sr_q[1][0];
  assign x2    = sr_q[2][0];
  assign x3    = sr_q[3][0];
  assign x4    = sr_q[4][0];
  assign x5    = sr_q[5][0];
  assign x6    = sr_q[6][0];
  assign x7    = sr_q[7][0];
  assign busy  = (state_q == RUN);
  assign valid = (state_q == DONE);
  assign y     = y_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Scoreboard bench for obc_shift_accumulator: ROMs are random lookup tables
// addressed by the bit slices; a recurrence model predicts every result.
module tb_obc_shift_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] xin [8];
  logic [31:0] offset_in;
  logic [7:0]  xb;
  logic [31:0] rom [4];
  logic        busy;
  logic        valid;
  logic [33:0] y;

  int          tbl [4][16];
  longint      cyc;
  logic [33:0] exp_q [$];
  logic [33:0] obs_y [$];
  longint      obs_c [$];
  int          n_tests;
  int          n_fails;

  obc_shift_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in0(xin[0]), .x_in1(xin[1]), .x_in2(xin[2]), .x_in3(xin[3]),
    .x_in4(xin[4]), .x_in5(xin[5]), .x_in6(xin[6]), .x_in7(xin[7]),
    .offset_in(offset_in),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]),
    .x4(xb[4]), .x5(xb[5]), .x6(xb[6]), .x7(xb[7]),
    .rom0(rom[0]), .rom1(rom[1]), .rom2(rom[2]), .rom3(rom[3]),
    .busy(busy), .valid(valid), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rom[0] = tbl[0][xb[3:0]];
    rom[1] = tbl[1][xb[7:4]];
    rom[2] = tbl[2][xb[3:0]];
    rom[3] = tbl[3][xb[7:4]];
  end

  always @(negedge clk) begin
    if (valid) begin
      obs_y.push_back(y);
      obs_c.push_back(cyc);
    end
  end

  // Independent recurrence model over the current samples and tables.
  function automatic logic [33:0] model(input logic [31:0] off);
    longint      acc;
    longint      s;
    logic [63:0] res;
    logic [3:0]  lo, hi;
    acc = 0;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      lo = {xin[3][k], xin[2][k], xin[1][k], xin[0][k]};
      hi = {xin[7][k], xin[6][k], xin[5][k], xin[4][k]};
      s = longint'(tbl[0][lo]) + longint'(tbl[1][hi]) +
          longint'(tbl[2][lo]) + longint'(tbl[3][hi]);
      if (k < 15) acc = (acc + s) >>> 1;
      else        res = acc - s + longint'($signed(off));
    end
    return res[33:0];
  endfunction

  task automatic fill_tables(input bit rnd);
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 16; i++)
        tbl[t][i] = rnd ? (int'($urandom) >>> 3) : 0;
  endtask

  task automatic rand_samples();
    for (int i = 0; i < 8; i++) xin[i] = 16'($urandom);
  endtask

  task automatic kick(output longint a);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit got,
                          output logic [33:0] yv, output longint c);
    int n;
    n = 0;
    while (obs_y.size() == 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    got = (obs_y.size() > 0);
    yv  = got ? obs_y.pop_front() : '0;
    c   = got ? obs_c.pop_front() : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    offset_in = '0;
    for (int i = 0; i < 8; i++) xin[i] = '0;
    fill_tables(1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({valid, busy, xb, y} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got valid=%b busy=%b x=%h y=%h, want all 0",
               valid, busy, xb, y);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({valid, busy} !== 2'b00) begin
      n_fails++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", valid, busy);
    end
  endtask

  task automatic test_const_rom();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    fill_tables(1'b0);
    for (int i = 0; i < 16; i++) tbl[0][i] = 32'h0020_0000;
    rand_samples();
    offset_in = '0;
    exp_q.push_back(model(offset_in));
    kick(a);
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== 34'h3_FFFF_FFC0 || yv !== e) begin
      n_fails++;
      $display("FAIL const_rom_y: got %h (seen=%0d), want 3ffffffc0 / model %h", yv, got, e);
    end
    n_tests++;
    if (c - a != 16) begin
      n_fails++;
      $display("FAIL const_rom_latency: got %0d cycles, want 16", c - a);
    end
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b0 || obs_y.size() != 0) begin
      n_fails++;
      $display("FAIL valid_one_cycle: got valid=%b extra=%0d, want 0 0", valid, obs_y.size());
    end
  endtask

  task automatic test_offset();
    longint a, c;
    bit got;
    logic [33:0] yv;
    fill_tables(1'b0);
    rand_samples();
    offset_in = 32'h0020_0000;
    exp_q.push_back(model(offset_in));
    kick(a);
    wait_obs(40, got, yv, c);
    void'(exp_q.pop_front());
    n_tests++;
    if (!got || yv !== 34'h0_0020_0000) begin
      n_fails++;
      $display("FAIL offset_only_y: got %h (seen=%0d), want 000200000", yv, got);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_y.size() != 0) begin
      n_fails++;
      $display("FAIL offset_single_pulse: got %0d extra pulses, want 0", obs_y.size());
    end
  endtask

  task automatic test_bit_slice();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    logic [7:0] ex;
    fill_tables(1'b1);
    for (int i = 0; i < 8; i++) xin[i] = '0;
    xin[0] = 16'h0001;
    xin[7] = 16'h8000;
    offset_in = 32'($urandom);
    exp_q.push_back(model(offset_in));
    @(negedge clk);
    n_tests++;
    if (xb !== 8'h00) begin
      n_fails++;
      $display("FAIL idle_bits: got x=%h, want 00", xb);
    end
    start = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      ex = {(k == 15), 6'b0, (k == 0)};
      n_tests++;
      if (xb !== ex || busy !== 1'b1) begin
        n_fails++;
        $display("FAIL bit_slice_%0d: got x=%h busy=%b, want x=%h busy=1", k, xb, busy, ex);
      end
    end
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== e || c - a != 16) begin
      n_fails++;
      $display("FAIL bit_slice_y: got %h after %0d, want %h after 16", yv, c - a, e);
    end
  endtask

  task automatic test_ignore_start();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    fill_tables(1'b1);
    rand_samples();
    offset_in = 32'($urandom);
    exp_q.push_back(model(offset_in));
    kick(a);
    repeat (4) @(negedge clk);
    rand_samples();
    offset_in = ~offset_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== e) begin
      n_fails++;
      $display("FAIL ignore_start_y: got %h (seen=%0d), want %h", yv, got, e);
    end
    n_tests++;
    if (c - a != 16) begin
      n_fails++;
      $display("FAIL ignore_start_latency: got %0d cycles, want 16", c - a);
    end
  endtask

  task automatic test_back_to_back();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    fill_tables(1'b1);
    rand_samples();
    offset_in = 32'($urandom);
    exp_q.push_back(model(offset_in));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    rand_samples();
    offset_in = 32'($urandom);
    exp_q.push_back(model(offset_in));
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== e || c - a != 16) begin
      n_fails++;
      $display("FAIL b2b_first: got %h after %0d, want %h after 16", yv, c - a, e);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_no_idle: got busy=%b after DONE, want 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== e || c - a != 33) begin
      n_fails++;
      $display("FAIL b2b_second: got %h after %0d, want %h after 33", yv, c - a, e);
    end
  endtask

  task automatic test_reset_mid_run();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    fill_tables(1'b1);
    for (int i = 0; i < 8; i++) xin[i] = 16'hFFFF;
    offset_in = 32'($urandom);
    kick(a);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({valid, busy, xb, y} !== '0) begin
      n_fails++;
      $display("FAIL async_reset: got valid=%b busy=%b x=%h y=%h, want all 0",
               valid, busy, xb, y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (obs_y.size() != 0) begin
      n_fails++;
      $display("FAIL no_valid_after_reset: got %0d pulses, want 0", obs_y.size());
      obs_y.delete();
      obs_c.delete();
    end
    rand_samples();
    exp_q.push_back(model(offset_in));
    kick(a);
    wait_obs(40, got, yv, c);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || yv !== e || c - a != 16) begin
      n_fails++;
      $display("FAIL post_reset_run: got %h after %0d, want %h after 16", yv, c - a, e);
    end
  endtask

  task automatic test_random();
    longint a, c;
    bit got;
    logic [33:0] yv, e;
    for (int r = 0; r < 20; r++) begin
      fill_tables(1'b1);
      rand_samples();
      offset_in = 32'($urandom);
      exp_q.push_back(model(offset_in));
      kick(a);
      wait_obs(40, got, yv, c);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || yv !== e || c - a != 16) begin
        n_fails++;
        $display("FAIL random_%0d: got %h after %0d, want %h after 16", r, yv, c - a, e);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fails = 0;
    test_reset();
    test_const_rom();
    test_offset();
    test_bit_slice();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
